// File: rtl/acq_sequencer_if.sv
// Waveform-buffer write port between acq_sequencer and the buffer RAM.
interface acq_sequencer_if #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 10
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/acq_sequencer.sv
// Single-waveform ADC acquisition sequencer: arm, level-crossing trigger, optional delay,
// DEPTH-sample capture into the buffer, then hold until readout is acknowledged.
module acq_sequencer #(
    parameter int DATA_W        = 14,
    parameter int DEPTH         = 1000,
    parameter int ADDR_W        = 10,
    parameter int TRIG_LEVEL    = 8192,
    parameter int DELAY_SAMPLES = 500,
    parameter int AUTO_TRIG     = 0
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    adc_a_i,
    input  logic [DATA_W-1:0]    adc_b_i,
    input  logic                 acquire_i,
    input  logic                 trig_source_i,
    input  logic                 trig_slope_i,
    input  logic                 delay_i,
    input  logic                 rd_ack_i,
    acq_sequencer_if.master      wr,
    output logic                 wave_done_o,
    output logic [15:0]          wave_number_o,
    output logic                 busy_o
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_DELAY   = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int DW = $clog2(DELAY_SAMPLES + 1);
    localparam int AW = (AUTO_TRIG > 1) ? $clog2(AUTO_TRIG) : 1;

    localparam logic [DATA_W-1:0] TRIG      = DATA_W'(TRIG_LEVEL);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DW-1:0]     DLY_LAST  = DW'(DELAY_SAMPLES - 1);
    localparam logic [AW-1:0]     AUTO_LAST = (AUTO_TRIG > 0) ? AW'(AUTO_TRIG - 1) : '0;

    logic [2:0]        state_q, state_d;
    logic              src_q, src_d;
    logic              slope_q, slope_d;
    logic              dly_en_q, dly_en_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [AW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [DW-1:0]     dly_cnt_q, dly_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic [15:0]       wnum_q, wnum_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] cur;
    logic              hit;
    logic              force_hit;

    assign cur       = src_q ? adc_b_i : adc_a_i;
    assign hit       = slope_q ? ((prev_q >= TRIG) && (cur <  TRIG))
                               : ((prev_q <  TRIG) && (cur >= TRIG));
    assign force_hit = (AUTO_TRIG != 0) && (wait_cnt_q == AUTO_LAST);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        slope_d    = slope_q;
        dly_en_d   = dly_en_q;
        prev_d     = cur;
        wait_cnt_d = wait_cnt_q;
        dly_cnt_d  = dly_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        wnum_d     = wnum_q;

        case (state_q)
            S_IDLE: begin
                if (acquire_i) state_d = S_ARM;
            end
            S_ARM: begin
                // prev must come from the newly selected channel, so bypass the latched source
                src_d      = trig_source_i;
                slope_d    = trig_slope_i;
                dly_en_d   = delay_i;
                prev_d     = trig_source_i ? adc_b_i : adc_a_i;
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (!acquire_i) begin
                    state_d = S_IDLE;
                end else if (hit || force_hit) begin
                    dly_cnt_d = '0;
                    if (dly_en_q) begin
                        state_d = S_DELAY;
                    end else begin
                        state_d   = S_CAPTURE;
                        wr_en_d   = 1'b1;
                        wr_addr_d = '0;
                        wr_data_d = cur;
                    end
                end
            end
            S_DELAY: begin
                dly_cnt_d = dly_cnt_q + 1'b1;
                if (dly_cnt_q == DLY_LAST) begin
                    state_d   = S_CAPTURE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = cur;
                end
            end
            S_CAPTURE: begin
                if (wr_addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    wnum_d  = wnum_q + 16'd1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    wr_data_d = cur;
                end
            end
            S_DONE: begin
                if (rd_ack_i) begin
                    done_d  = 1'b0;
                    state_d = acquire_i ? S_ARM : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_ARM) || (state_d == S_WAIT) ||
                 (state_d == S_DELAY) || (state_d == S_CAPTURE);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            src_q      <= 1'b0;
            slope_q    <= 1'b0;
            dly_en_q   <= 1'b0;
            prev_q     <= '0;
            wait_cnt_q <= '0;
            dly_cnt_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            wnum_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            slope_q    <= slope_d;
            dly_en_q   <= dly_en_d;
            prev_q     <= prev_d;
            wait_cnt_q <= wait_cnt_d;
            dly_cnt_q  <= dly_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            wnum_q     <= wnum_d;
            busy_q     <= busy_d;
        end
    end

    assign wr.wr_en      = wr_en_q;
    assign wr.wr_addr    = wr_addr_q;
    assign wr.wr_data    = wr_data_q;
    assign wave_done_o   = done_q;
    assign wave_number_o = wnum_q;
    assign busy_o        = busy_q;
endmodule
